// File: rtl/pipeline_share_arb_if.sv
// Handshake bundle between the shared-pipeline arbiter, its requesters
// and the pipeline itself. "master" is the arbiter view, "slave" the
// view of everything around it.
interface pipeline_share_arb_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            req_avail;
  logic [N_REQ-1:0]            req_get;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic                        pipe_avail;
  logic                        pipe_get;
  logic [DATA_WIDTH-1:0]       pipe_data;
  logic                        pipe_post_avail;
  logic                        pipe_post_get;
  logic [DATA_WIDTH-1:0]       pipe_post_data;
  logic [N_REQ-1:0]            rsp_avail;
  logic [N_REQ-1:0]            rsp_get;
  logic [DATA_WIDTH-1:0]       rsp_data;

  modport master (
    input  req_avail, req_data, pipe_get, pipe_post_avail, pipe_post_data, rsp_get,
    output req_get, pipe_avail, pipe_data, pipe_post_get, rsp_avail, rsp_data
  );

  modport slave (
    output req_avail, req_data, pipe_get, pipe_post_avail, pipe_post_data, rsp_get,
    input  req_get, pipe_avail, pipe_data, pipe_post_get, rsp_avail, rsp_data
  );
endinterface

// File: rtl/pipeline_share_arb.sv
// Round-robin sharing of one in-order avail/get pipeline between N_REQ
// requesters. Accepted words leave their requester index in a tag FIFO;
// results coming out of the pipeline are steered back to the tag at the
// FIFO head. Purely combinational on both datapaths: no added latency.
module pipeline_share_arb #(
  parameter int  N_REQ      = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  TAG_DEPTH  = 8,
  localparam int CNT_W      = $clog2(TAG_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_share_arb_if.master   bus,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   err_orphan
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] sel;
  logic [TAG_W-1:0] idx;
  logic [TAG_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Occupancy flags come from registered state only, so a pop at full
  // cannot open the pre side in the same cycle.
  assign full  = (outstanding == CNT_W'(TAG_DEPTH));
  assign empty = (outstanding == '0);
  assign head  = tag_mem[rd_ptr];

  // Round-robin pick: scan downwards so the candidate nearest rr_ptr wins.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = TAG_W'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req_avail[idx]) sel = idx;
    end
  end

  // Pre side: grant, data mux; every handshake output is held low in reset.
  always_comb begin
    bus.pipe_avail = rst_n && (|bus.req_avail) && !full;
    push           = bus.pipe_avail && bus.pipe_get;
    bus.req_get    = '0;
    if (push) bus.req_get[sel] = 1'b1;
    bus.pipe_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (TAG_W'(i) == sel) bus.pipe_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Return side: route to the head tag; other requesters' rsp_get is ignored.
  always_comb begin
    bus.rsp_avail = '0;
    if (rst_n && bus.pipe_post_avail && !empty) bus.rsp_avail[head] = 1'b1;
    bus.pipe_post_get = rst_n && !empty && bus.rsp_get[head];
    bus.rsp_data      = bus.pipe_post_data;
    pop               = bus.pipe_post_get && bus.pipe_post_avail;
  end

  // Control state: arbiter pointer, FIFO pointers, occupancy, sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (sel == TAG_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (bus.pipe_post_avail && empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage; contents are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

endmodule
